fft2d_corner_turn: RTL
======================

# fft2d_corner_turn

Parametrised, ping-pong corner-turn (transpose) buffer between the row-FFT and column-FFT stages of the 2D FFT datapath. It accepts one complete row of complex samples per beat and emits one complete column per beat, with valid/ready handshakes on both sides. It replaces the fixed 8x8, non-backpressured shift-register transpose with any ROWS x COLS frame size and overlaps the fill of one frame with the drain of the previous one.

## Interface
- DATALEN, 16, bits per real or imaginary part; CMPLXLEN = 2*DATALEN.
- ROWS, 8, rows per frame (>=2); equals the number of beats in and the number of samples per output beat.
- COLS, 8, columns per frame (>=2); equals the number of samples per input beat and the number of beats out.
- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous drop of all buffered and partial frames.
- in_valid  in  1  row beat valid.
- in_ready  out  1  buffer can accept a row.
- in_data  in  COLS*CMPLXLEN  row; sample j at [j*CMPLXLEN +: CMPLXLEN], with the real part in the low DATALEN bits and the imaginary part in the high DATALEN bits.
- out_valid  out  1  column beat valid.
- out_ready  in  1  downstream accepts column.
- out_data  out  ROWS*CMPLXLEN  column; sample i is row i of the current column, same packing as in_data.
- out_first  out  1  out_valid and column index 0.
- out_last  out  1  out_valid and column index COLS-1.

## Operation
- Storage: two banks B0 and B1, each ROWS x COLS x CMPLXLEN registers.
- Per-bank full flag. Write bank pointer wb and read bank pointer rb, both starting at B0.
- Write row counter wr_row counts 0..ROWS-1. Read column counter rd_col counts 0..COLS-1.
- in_ready = !full[wb].
- On an input handshake:
  - write in_data into row wr_row of bank wb;
  - increment wr_row;
  - when wr_row reaches ROWS-1: set full[wb], toggle wb, reset wr_row to 0.
- out_valid = full[rb]. out_data = column rd_col of bank rb.
- On an output handshake:
  - increment rd_col;
  - when rd_col reaches COLS-1: clear full[rb], toggle rb, reset rd_col to 0.
- The write side and the read side can never address the same bank in the same cycle: writing requires !full, reading requires full. A simultaneous set of one bank and clear of the other is legal and is applied in the same cycle.
- Per-bank state sequence: EMPTY -> FILLING (wr_row>0) -> FULL -> DRAINING (rd_col>0) -> EMPTY.
- When out_valid=1 and out_ready=0, out_data must stay stable.
- flush has priority over any handshake in the same cycle:
  - clears both full flags;
  - resets wb, rb, wr_row and rd_col;
  - leaves storage contents untouched.
- No arithmetic is performed; data passes bit-exact.

## Timing
- Reset values: in_ready=1, out_valid=0, out_first=0, out_last=0, wb=rb=B0, both counters 0. out_data is don't-care.
- Latency: out_valid rises the cycle after the clock edge that accepts the last row of a frame.
- out_data, out_first and out_last are decoded from registered state only; there is no combinational path from in_* to out_*.
- in_ready depends on registered state only, so it does not depend on in_valid in the same cycle.
- Throughput, ROWS==COLS: continuous streaming at 1 row/clk in and 1 column/clk out with no bubbles.
- Throughput, ROWS!=COLS: the slower side sets the rate, and backpressure appears on in_ready.
- Both banks full: in_ready=0 until the first output handshake of the final column of bank rb; in_ready is 1 in the following cycle.
- Reset asserted mid-frame: all state returns to reset values immediately, and partial frames are lost.

## Structure
- The shared package fft2d_pkg holds:
  - the CMPLXLEN derivation;
  - re/im slice helper functions;
  - the packing-order constants reused by the row-FFT and column-FFT wrappers.
- One natural sub-module, fft2d_ct_bank. It is instantiated twice and contains:
  - a ROWS x COLS register array;
  - a row write port (we, row index, row data);
  - a column read port (column index -> ROWS samples).
- The top level holds the full flags, pointers, counters and handshake logic.

## Test plan
In all scenarios DATALEN=16, ROWS=COLS=8, and the sample at row r, column c has real = r*16+c and imag = ~(r*16+c).
- Single frame: 8 row beats back-to-back with out_ready=1.
  - out_valid rises 1 cycle after the 8th beat.
  - Column c carries real values c, 16+c, ..., 112+c.
  - out_first is high on c=0 and out_last on c=7.
- Continuous streaming of 4 frames with out_ready=1: in_ready stays 1 throughout, and all 32 columns match the transpose of their frame in order.
- Backpressure with out_ready=0: after 16 accepted rows, in_ready=0 and out_data holds column 0 of frame 0. Raise out_ready for 8 cycles: in_ready returns to 1 the cycle after the 8th output handshake.
- Random stalls: in_valid and out_ready each toggled randomly at 50% over 20 frames. The output must equal the scoreboard transpose, with no duplicated or dropped beats.
- Flush: accept 3 rows, then assert flush together with in_valid.
  - That beat is dropped and out_valid stays 0.
  - A subsequent full frame emerges intact as the first frame.
- Asynchronous reset mid-drain (rd_col=4): all outputs take their reset values immediately. A new frame after reset is transposed correctly.

Source files
------------

// File: rtl/fft2d_pkg.sv
// Shared 2D FFT datapath definitions: complex sample width, re/im packing
// order and slice helpers used by the row-FFT, corner-turn and column-FFT.
package fft2d_pkg;

  localparam int DATALEN_DEF  = 16;
  localparam int CMPLXLEN_DEF = 2 * DATALEN_DEF;

  // Packing order: slot index in DATALEN units inside one complex sample,
  // and sample 0 of a beat sits at the least significant end.
  localparam int RE_SLOT     = 0;
  localparam int IM_SLOT     = 1;
  localparam int SAMPLE0_LSB = 0;

  function automatic int cmplxlen(input int datalen);
    return 2 * datalen;
  endfunction

  function automatic logic [DATALEN_DEF-1:0] cx_re(input logic [CMPLXLEN_DEF-1:0] x);
    return x[RE_SLOT*DATALEN_DEF +: DATALEN_DEF];
  endfunction

  function automatic logic [DATALEN_DEF-1:0] cx_im(input logic [CMPLXLEN_DEF-1:0] x);
    return x[IM_SLOT*DATALEN_DEF +: DATALEN_DEF];
  endfunction

  function automatic logic [CMPLXLEN_DEF-1:0] cx_pack(input logic [DATALEN_DEF-1:0] re,
                                                      input logic [DATALEN_DEF-1:0] im);
    logic [CMPLXLEN_DEF-1:0] x;
    x = '0;
    x[RE_SLOT*DATALEN_DEF +: DATALEN_DEF] = re;
    x[IM_SLOT*DATALEN_DEF +: DATALEN_DEF] = im;
    return x;
  endfunction

endpackage

// File: rtl/fft2d_ct_bank.sv
// One corner-turn bank: ROWS x COLS complex registers, written a row at a
// time and read a column at a time.
module fft2d_ct_bank
  import fft2d_pkg::*;
#(
  parameter  int DATALEN  = 16,
  parameter  int ROWS     = 8,
  parameter  int COLS     = 8,
  localparam int CMPLXLEN = cmplxlen(DATALEN),
  localparam int RW       = $clog2(ROWS),
  localparam int CLW      = $clog2(COLS)
) (
  input  logic                               clk,
  input  logic                               we,
  input  logic [RW-1:0]                      wr_row,
  input  logic [COLS-1:0][CMPLXLEN-1:0]      wr_data,
  input  logic [CLW-1:0]                     rd_col,
  output logic [ROWS-1:0][CMPLXLEN-1:0]      rd_data
);

  // Storage has no reset: contents are only observable once the owning
  // full flag is set, which implies every row was rewritten.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic [COLS-1:0][CMPLXLEN-1:0] row_q;

    always_ff @(posedge clk)
      if (we && (wr_row == RW'(r)))
        row_q <= wr_data;

    assign rd_data[r] = row_q[rd_col];
  end

endmodule

// File: rtl/fft2d_corner_turn.sv
// Ping-pong corner-turn buffer: rows in, columns out, with valid/ready on
// both sides; one bank fills while the other drains.
module fft2d_corner_turn
  import fft2d_pkg::*;
#(
  parameter  int DATALEN  = 16,
  parameter  int ROWS     = 8,
  parameter  int COLS     = 8,
  localparam int CMPLXLEN = cmplxlen(DATALEN)
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [COLS*CMPLXLEN-1:0]  in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ROWS*CMPLXLEN-1:0]  out_data,
  output logic                      out_first,
  output logic                      out_last
);

  localparam int RW  = $clog2(ROWS);
  localparam int CLW = $clog2(COLS);

  logic [1:0]                          full, full_nxt;
  logic                                wb, rb;
  logic [RW-1:0]                       wr_row;
  logic [CLW-1:0]                      rd_col;
  logic                                in_fire, out_fire, wr_last, rd_last;
  logic [1:0]                          bank_we;
  logic [1:0][ROWS-1:0][CMPLXLEN-1:0]  bank_rd;

  assign in_ready  = !full[wb];
  assign out_valid = full[rb];
  assign in_fire   = in_valid  && in_ready  && !flush;
  assign out_fire  = out_valid && out_ready && !flush;
  assign wr_last   = (wr_row == RW'(ROWS-1));
  assign rd_last   = (rd_col == CLW'(COLS-1));

  for (genvar b = 0; b < 2; b++) begin : g_bank
    assign bank_we[b] = in_fire && (wb == 1'(b));

    fft2d_ct_bank #(
      .DATALEN (DATALEN),
      .ROWS    (ROWS),
      .COLS    (COLS)
    ) u_bank (
      .clk     (clk),
      .we      (bank_we[b]),
      .wr_row  (wr_row),
      .wr_data (in_data),
      .rd_col  (rd_col),
      .rd_data (bank_rd[b])
    );
  end

  assign out_data  = bank_rd[rb];
  assign out_first = out_valid && (rd_col == '0);
  assign out_last  = out_valid && rd_last;

  // Write and read sides always own different banks, so setting one flag
  // and clearing the other in the same cycle never collide.
  always_comb begin
    full_nxt = full;
    if (in_fire && wr_last)
      full_nxt[wb] = 1'b1;
    if (out_fire && rd_last)
      full_nxt[rb] = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      full   <= '0;
      wb     <= 1'b0;
      rb     <= 1'b0;
      wr_row <= '0;
      rd_col <= '0;
    end else if (flush) begin
      full   <= '0;
      wb     <= 1'b0;
      rb     <= 1'b0;
      wr_row <= '0;
      rd_col <= '0;
    end else begin
      full <= full_nxt;
      if (in_fire) begin
        if (wr_last) begin
          wr_row <= '0;
          wb     <= !wb;
        end else begin
          wr_row <= wr_row + RW'(1);
        end
      end
      if (out_fire) begin
        if (rd_last) begin
          rd_col <= '0;
          rb     <= !rb;
        end else begin
          rd_col <= rd_col + CLW'(1);
        end
      end
    end
  end

endmodule
